ddr_axi_burst_master: RTL

Synthesizable AXI-style burst initiator that drives the DDR slave port (write address/data/response and read address/data channels) from a simple single-command interface. It sits between local datapath logic (command issuer, write-data source, read-data sink) and the DDR controller. It executes one INCR burst at a time, generates write LAST from a beat counter, forwards read beats with backpressure, and checks response, ID and LAST consistency.

---
 rtl/ddr_axi_burst_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_axi_burst_master.sv
// ddr_axi_burst_master: single-command AXI-style INCR burst initiator for the
// DDR slave port. One burst in flight; write/read data are passed straight
// through between the local streams and the DDR data channels.
module ddr_axi_burst_master #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic                  DDR_MASTER_CLK,
    input  logic                  DDR_MASTER_RST,

    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [31:0]           CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic [ID_W-1:0]       CMD_ID,

    input  logic [DATA_W-1:0]     WR_IN_DATA,
    input  logic                  WR_IN_VALID,
    output logic                  WR_IN_READY,

    output logic [DATA_W-1:0]     RD_OUT_DATA,
    output logic                  RD_OUT_VALID,
    input  logic                  RD_OUT_READY,
    output logic                  RD_OUT_LAST,

    output logic                  DONE,
    output logic [1:0]            DONE_ERR,

    output logic [ID_W-1:0]       DDR_MASTER_WR_ADDR_ID,
    output logic [31:0]           DDR_MASTER_WR_ADDR_ADDR,
    output logic [7:0]            DDR_MASTER_WR_ADDR_LEN,
    output logic [1:0]            DDR_MASTER_WR_ADDR_BURST,
    output logic                  DDR_MASTER_WR_ADDR_VALID,
    input  logic                  DDR_MASTER_WR_ADDR_READY,

    output logic [DATA_W-1:0]     DDR_MASTER_WR_DATA,
    output logic [DATA_W/8-1:0]   DDR_MASTER_WR_DATA_STRB,
    output logic                  DDR_MASTER_WR_DATA_LAST,
    output logic                  DDR_MASTER_WR_DATA_VALID,
    input  logic                  DDR_MASTER_WR_DATA_READY,

    input  logic [ID_W-1:0]       DDR_MASTER_WR_BACK_ID,
    input  logic [1:0]            DDR_MASTER_WR_BACK_RESP,
    input  logic                  DDR_MASTER_WR_BACK_VALID,
    output logic                  DDR_MASTER_WR_BACK_READY,

    output logic [ID_W-1:0]       DDR_MASTER_RD_ADDR_ID,
    output logic [31:0]           DDR_MASTER_RD_ADDR_ADDR,
    output logic [7:0]            DDR_MASTER_RD_ADDR_LEN,
    output logic [1:0]            DDR_MASTER_RD_ADDR_BURST,
    output logic                  DDR_MASTER_RD_ADDR_VALID,
    input  logic                  DDR_MASTER_RD_ADDR_READY,

    input  logic [ID_W-1:0]       DDR_MASTER_RD_BACK_ID,
    input  logic [DATA_W-1:0]     DDR_MASTER_RD_BACK_DATA,
    input  logic [1:0]            DDR_MASTER_RD_BACK_DATA_RESP,
    input  logic                  DDR_MASTER_RD_BACK_DATA_LAST,
    input  logic                  DDR_MASTER_RD_BACK_DATA_VALID,
    output logic                  DDR_MASTER_RD_BACK_DATA_READY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_RESP = 2'b01;
    localparam logic [1:0] ERR_ID   = 2'b10;
    localparam logic [1:0] ERR_LAST = 2'b11;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr_r;
    logic [7:0]        len_r;
    logic [ID_W-1:0]   id_r;
    logic [7:0]        beat;
    logic [1:0]        err;
    logic              drain;

    logic              cmd_hs;
    logic              w_hs;
    logic              b_hs;
    logic              rd_ready;
    logic              r_hs;
    logic              beat_last;
    logic [1:0]        b_err;
    logic [1:0]        r_err;

    // Handshake decode and per-beat error classification
    always_comb begin
        beat_last = (beat == len_r);
        cmd_hs    = (state == IDLE) && CMD_VALID;
        w_hs      = (state == WR_DATA) && WR_IN_VALID && DDR_MASTER_WR_DATA_READY;
        b_hs      = (state == WR_RESP) && DDR_MASTER_WR_BACK_VALID;
        rd_ready  = (state == RD_DATA) && (drain || RD_OUT_READY);
        r_hs      = rd_ready && DDR_MASTER_RD_BACK_DATA_VALID;

        if (DDR_MASTER_WR_BACK_RESP != 2'b00)
            b_err = ERR_RESP;
        else if (DDR_MASTER_WR_BACK_ID != id_r)
            b_err = ERR_ID;
        else
            b_err = ERR_OK;

        if (DDR_MASTER_RD_BACK_DATA_RESP != 2'b00)
            r_err = ERR_RESP;
        else if (DDR_MASTER_RD_BACK_ID != id_r)
            r_err = ERR_ID;
        else if (DDR_MASTER_RD_BACK_DATA_LAST != beat_last)
            r_err = ERR_LAST;
        else
            r_err = ERR_OK;
    end

    // State register
    always_ff @(posedge DDR_MASTER_CLK or posedge DDR_MASTER_RST) begin
        if (DDR_MASTER_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CMD_VALID) state_nxt = CMD_WRITE ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (DDR_MASTER_WR_ADDR_READY) state_nxt = WR_DATA;
            WR_DATA: if (w_hs && beat_last) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = FINISH;
            RD_ADDR: if (DDR_MASTER_RD_ADDR_READY) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && DDR_MASTER_RD_BACK_DATA_LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command registers, beat counter, sticky error and overrun-drain flag
    always_ff @(posedge DDR_MASTER_CLK or posedge DDR_MASTER_RST) begin
        if (DDR_MASTER_RST) begin
            addr_r <= '0;
            len_r  <= '0;
            id_r   <= '0;
            beat   <= '0;
            err    <= ERR_OK;
            drain  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_r <= CMD_ADDR;
                len_r  <= CMD_LEN;
                id_r   <= CMD_ID;
                beat   <= '0;
                err    <= ERR_OK;
                drain  <= 1'b0;
            end
            if (w_hs && !beat_last)
                beat <= beat + 8'd1;
            if (b_hs)
                err <= b_err;
            // Once beat LEN has passed without LAST, remaining beats are only swallowed
            if (r_hs && !drain) begin
                if (err == ERR_OK)
                    err <= r_err;
                if (!DDR_MASTER_RD_BACK_DATA_LAST) begin
                    if (beat_last)
                        drain <= 1'b1;
                    else
                        beat <= beat + 8'd1;
                end
            end
        end
    end

    // Output decode from the current state
    always_comb begin
        CMD_READY                     = (state == IDLE);
        DONE                          = (state == FINISH);
        DONE_ERR                      = (state == FINISH) ? err : ERR_OK;

        DDR_MASTER_WR_ADDR_ID         = id_r;
        DDR_MASTER_WR_ADDR_ADDR       = addr_r;
        DDR_MASTER_WR_ADDR_LEN        = len_r;
        DDR_MASTER_WR_ADDR_BURST      = 2'b01;
        DDR_MASTER_WR_ADDR_VALID      = (state == WR_ADDR);

        DDR_MASTER_WR_DATA            = WR_IN_DATA;
        DDR_MASTER_WR_DATA_STRB       = '1;
        DDR_MASTER_WR_DATA_LAST       = 1'b0;
        DDR_MASTER_WR_DATA_VALID      = 1'b0;
        WR_IN_READY                   = 1'b0;

        DDR_MASTER_WR_BACK_READY      = (state == WR_RESP);

        DDR_MASTER_RD_ADDR_ID         = id_r;
        DDR_MASTER_RD_ADDR_ADDR       = addr_r;
        DDR_MASTER_RD_ADDR_LEN        = len_r;
        DDR_MASTER_RD_ADDR_BURST      = 2'b01;
        DDR_MASTER_RD_ADDR_VALID      = (state == RD_ADDR);

        DDR_MASTER_RD_BACK_DATA_READY = rd_ready;
        RD_OUT_DATA                   = DDR_MASTER_RD_BACK_DATA;
        RD_OUT_VALID                  = 1'b0;
        RD_OUT_LAST                   = 1'b0;

        if (state == WR_DATA) begin
            DDR_MASTER_WR_DATA_VALID = WR_IN_VALID;
            WR_IN_READY              = DDR_MASTER_WR_DATA_READY;
            DDR_MASTER_WR_DATA_LAST  = beat_last;
        end

        if (state == RD_DATA && !drain) begin
            RD_OUT_VALID = DDR_MASTER_RD_BACK_DATA_VALID;
            RD_OUT_LAST  = beat_last;
        end
    end

endmodule
